// File: rtl/hv_dac_reg_bank_if.sv
// DCS register bus between a bus master and the HV DAC register bank.
//   wr_en/wr_addr/wr_data : single-cycle write strobe, 6-bit address, 16-bit data
//   rd_en/rd_addr         : single-cycle read strobe and address
//   rd_data/rd_valid      : read response, valid one cycle after rd_en
interface hv_dac_reg_bank_if;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [15:0] wr_data;
  logic        rd_en;
  logic [5:0]  rd_addr;
  logic [15:0] rd_data;
  logic        rd_valid;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/hv_dac_reg_bank.sv
// HV DAC register bank: upstream feeder for the HV DAC serializer.
// Channel settings are written into a shadow bank over the DCS register bus;
// a commit copies the shadow bank into the active bank (hv_reg_din) and
// raises hv_update for PULSE_LEN cycles, followed by a holdoff window so the
// serializer is never retriggered mid-transfer.
// Ports:
//   clkin      : system clock, rising edge
//   reset      : asynchronous, active-low reset
//   bus        : register bus (slave side)
//   hv_reg_din : active bank, channel k at bits [10k+9:10k]
//   hv_update  : update strobe to the serializer
//   busy       : high in LOAD, PULSE and HOLD
// Address map: 0..NCH-1 channels, 32 CTRL, 33 HV_MAX, 34 STATUS (RO).
module hv_dac_reg_bank #(
  parameter int unsigned NCH        = 32,
  parameter int unsigned PULSE_LEN  = 4,
  parameter int unsigned HOLDOFF    = 4096,
  parameter logic [9:0]  HV_MAX_RST = 10'h3FF
) (
  input  logic                 clkin,
  input  logic                 reset,
  hv_dac_reg_bank_if.slave     bus,
  output logic [NCH*10-1:0]    hv_reg_din,
  output logic                 hv_update,
  output logic                 busy
);

  localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [5:0] ADDR_CTRL   = 6'd32;
  localparam logic [5:0] ADDR_HVMAX  = 6'd33;
  localparam logic [5:0] ADDR_STATUS = 6'd34;

  typedef enum logic [1:0] {IDLE, LOAD, PULSE, HOLD} state_t;

  state_t                 state, state_nxt;
  logic [NCH-1:0][9:0]    shadow;
  logic [NCH-1:0][9:0]    active;
  logic [9:0]             hv_max;
  logic                   auto_commit;
  logic                   pending;
  logic                   clamp_flag;
  logic [15:0]            cnt;

  logic                   ch_wr;
  logic                   rd_ch_sel;
  logic                   commit_req;
  logic [9:0]             wr_val;
  logic [CW-1:0]          wr_ch;
  logic [CW-1:0]          rd_ch;
  logic [15:0]            rd_mux;
  logic                   unused_wr_hi;

  assign unused_wr_hi = ^bus.wr_data[15:10];

  assign hv_reg_din = active;
  assign hv_update  = (state == PULSE);
  assign busy       = (state != IDLE);

  always_comb begin
    wr_val     = bus.wr_data[9:0];
    wr_ch      = bus.wr_addr[CW-1:0];
    rd_ch      = bus.rd_addr[CW-1:0];
    ch_wr      = bus.wr_en && (32'(bus.wr_addr) < NCH);
    rd_ch_sel  = (32'(bus.rd_addr) < NCH);
    commit_req = (bus.wr_en && (bus.wr_addr == ADDR_CTRL) && bus.wr_data[0])
               || (ch_wr && auto_commit);
  end

  // Read mux samples current register values, so a same-cycle write to the
  // same address is seen only by the next read.
  always_comb begin
    rd_mux = '0;
    if (rd_ch_sel) begin
      rd_mux = {6'b0, shadow[rd_ch]};
    end else begin
      case (bus.rd_addr)
        ADDR_CTRL:   rd_mux = {14'b0, auto_commit, 1'b0};
        ADDR_HVMAX:  rd_mux = {6'b0, hv_max};
        ADDR_STATUS: rd_mux = {13'b0, clamp_flag, pending, busy};
        default:     rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pending || commit_req) state_nxt = LOAD;
      LOAD:    state_nxt = PULSE;
      PULSE:   if (cnt == 16'(PULSE_LEN - 1)) state_nxt = HOLD;
      HOLD:    if (cnt >= 16'(HOLDOFF)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      shadow       <= '0;
      active       <= '0;
      hv_max       <= HV_MAX_RST;
      auto_commit  <= 1'b0;
      pending      <= 1'b0;
      clamp_flag   <= 1'b0;
      cnt          <= '0;
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
    end else begin
      bus.rd_valid <= bus.rd_en;
      if (bus.rd_en) bus.rd_data <= rd_mux;

      // Clear-on-read first so a clamping write in the same cycle still sets it.
      if (bus.rd_en && (bus.rd_addr == ADDR_STATUS)) clamp_flag <= 1'b0;

      if (ch_wr) begin
        if (wr_val > hv_max) begin
          shadow[wr_ch] <= hv_max;
          clamp_flag    <= 1'b1;
        end else begin
          shadow[wr_ch] <= wr_val;
        end
      end else if (bus.wr_en && (bus.wr_addr == ADDR_CTRL)) begin
        auto_commit <= bus.wr_data[1];
      end else if (bus.wr_en && (bus.wr_addr == ADDR_HVMAX)) begin
        hv_max <= bus.wr_data[9:0];
      end

      // The copy uses the pre-edge shadow, so a channel write landing in LOAD
      // is excluded and only re-arms pending if it is itself a request.
      if (state == LOAD) active <= shadow;

      if (state == LOAD) pending <= 1'b0;
      if (commit_req && (state != IDLE)) pending <= 1'b1;

      // One counter spans PULSE and HOLD, measured from PULSE entry.
      if (state == LOAD) begin
        cnt <= '0;
      end else if ((state == PULSE) || (state == HOLD)) begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_hv_dac_reg_bank.sv
module tb_hv_dac_reg_bank;
  localparam int EXP_PULSE = 4;
  localparam int EXP_BUSY  = 4097;

  logic         clkin = 1'b0;
  logic         reset = 1'b0;
  logic [319:0] hv_reg_din;
  logic         hv_update;
  logic         busy;

  hv_dac_reg_bank_if bus();

  hv_dac_reg_bank #(
    .NCH(32),
    .PULSE_LEN(4),
    .HOLDOFF(4096),
    .HV_MAX_RST(10'h3FF)
  ) dut (
    .clkin(clkin),
    .reset(reset),
    .bus(bus),
    .hv_reg_din(hv_reg_din),
    .hv_update(hv_update),
    .busy(busy)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    bit          is_wr;
    logic [5:0]  addr;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } rd_exp_t;

  vec_t    tbl[$];
  rd_exp_t sb[$];
  rd_exp_t mon_e;
  int      n_cmp = 0;
  int      n_bad = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clkin) begin
    if (bus.rd_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rd_unexpected: got rd_valid=1 data 0x%0h, expected no read", bus.rd_data);
      end else begin
        mon_e = sb.pop_front();
        check(mon_e.name, 32'(bus.rd_data), 32'(mon_e.exp));
      end
    end
  end

  function automatic vec_t vec(bit w, logic [5:0] a, logic [15:0] d, logic [15:0] e);
    vec_t v;
    v.is_wr = w;
    v.addr  = a;
    v.data  = d;
    v.exp   = e;
    return v;
  endfunction

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic do_write(logic [5:0] addr, logic [15:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic do_read(logic [5:0] addr, logic [15:0] exp, string name);
    bus.rd_en   = 1'b1;
    bus.rd_addr = addr;
    sb.push_back('{name, exp});
    tick();
    bus.rd_en   = 1'b0;
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    while (busy && n < 6000) begin
      n++;
      tick();
    end
    check(name, 32'(busy), 0);
  endtask

  task automatic run_commit_check(string tag);
    logic [319:0] snap;
    int n_up, n_busy;
    bit changed;
    do_write(6'd0, 16'd1);
    do_write(6'd31, 16'd32);
    do_write(6'd32, 16'h0001);
    check({tag, "_load_busy"}, 32'(busy), 1);
    check({tag, "_load_upd"}, 32'(hv_update), 0);
    check({tag, "_load_din_old"}, 32'(hv_reg_din[9:0]), 0);
    tick();
    check({tag, "_ch0"}, 32'(hv_reg_din[9:0]), 1);
    check({tag, "_ch31"}, 32'(hv_reg_din[319:310]), 32);
    check({tag, "_upd_rise"}, 32'(hv_update), 1);
    snap = hv_reg_din;
    changed = 1'b0;
    n_up = 0;
    n_busy = 0;
    while (busy && n_busy < 6000) begin
      if (hv_update) n_up++;
      if (hv_reg_din !== snap) changed = 1'b1;
      n_busy++;
      tick();
    end
    check({tag, "_pulse_len"}, 32'(n_up), EXP_PULSE);
    check({tag, "_busy_len"}, 32'(n_busy), EXP_BUSY);
    check({tag, "_din_stable"}, 32'(changed), 0);
  endtask

  initial begin
    logic [319:0] snap;
    bit changed;
    int n, rises;
    logic prev;

    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_en = 1'b0; bus.rd_addr = '0;

    tbl.push_back(vec(0, 6'd34, 16'h0000, 16'h0000));
    tbl.push_back(vec(0, 6'd33, 16'h0000, 16'h03FF));
    tbl.push_back(vec(0, 6'd32, 16'h0000, 16'h0000));
    tbl.push_back(vec(0, 6'd0,  16'h0000, 16'h0000));
    tbl.push_back(vec(1, 6'd0,  16'd1,    16'h0000));
    tbl.push_back(vec(1, 6'd31, 16'd32,   16'h0000));
    tbl.push_back(vec(0, 6'd0,  16'h0000, 16'd1));
    tbl.push_back(vec(0, 6'd31, 16'h0000, 16'd32));
    tbl.push_back(vec(1, 6'd2,  16'hFC05, 16'h0000));
    tbl.push_back(vec(0, 6'd2,  16'h0000, 16'h0005));
    tbl.push_back(vec(1, 6'd33, 16'd500,  16'h0000));
    tbl.push_back(vec(0, 6'd33, 16'h0000, 16'd500));
    tbl.push_back(vec(1, 6'd5,  16'd800,  16'h0000));
    tbl.push_back(vec(0, 6'd5,  16'h0000, 16'd500));
    tbl.push_back(vec(0, 6'd34, 16'h0000, 16'h0004));
    tbl.push_back(vec(0, 6'd34, 16'h0000, 16'h0000));
    tbl.push_back(vec(1, 6'd33, 16'd100,  16'h0000));
    tbl.push_back(vec(0, 6'd5,  16'h0000, 16'd500));
    tbl.push_back(vec(0, 6'd33, 16'h0000, 16'd100));
    tbl.push_back(vec(1, 6'd33, 16'h03FF, 16'h0000));
    tbl.push_back(vec(1, 6'd34, 16'hFFFF, 16'h0000));
    tbl.push_back(vec(0, 6'd34, 16'h0000, 16'h0000));
    tbl.push_back(vec(1, 6'd40, 16'd123,  16'h0000));
    tbl.push_back(vec(0, 6'd40, 16'h0000, 16'h0000));
    tbl.push_back(vec(0, 6'd8,  16'h0000, 16'h0000));
    tbl.push_back(vec(1, 6'd35, 16'd7,    16'h0000));
    tbl.push_back(vec(0, 6'd35, 16'h0000, 16'h0000));
    tbl.push_back(vec(1, 6'd6,  16'h03FF, 16'h0000));
    tbl.push_back(vec(0, 6'd6,  16'h0000, 16'h03FF));
    tbl.push_back(vec(0, 6'd34, 16'h0000, 16'h0000));

    // Reset state
    repeat (3) @(posedge clkin);
    #1;
    check("rst_upd", 32'(hv_update), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_din", 32'(|hv_reg_din), 0);
    check("rst_rd_valid", 32'(bus.rd_valid), 0);
    @(negedge clkin);
    reset = 1'b1;
    tick();

    // Register access vectors
    foreach (tbl[i]) begin
      if (tbl[i].is_wr) do_write(tbl[i].addr, tbl[i].data);
      else do_read(tbl[i].addr, tbl[i].exp, $sformatf("tbl%0d_rd_a%0d", i, tbl[i].addr));
    end

    // Same-cycle read and write of ch7 returns the old value; rd_data holds
    do_write(6'd7, 16'd10);
    bus.wr_en = 1'b1; bus.wr_addr = 6'd7; bus.wr_data = 16'd20;
    bus.rd_en = 1'b1; bus.rd_addr = 6'd7;
    sb.push_back('{"rw_same_cycle_old", 16'd10});
    tick();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    do_read(6'd7, 16'd20, "rw_after_new");
    tick();
    check("rd_valid_drop", 32'(bus.rd_valid), 0);
    check("rd_data_hold", 32'(bus.rd_data), 20);

    // First commit: latency, pulse width, holdoff
    run_commit_check("s1");

    // Commit requested during HOLD is deferred, then serviced after one idle cycle
    do_write(6'd32, 16'h0001);
    tick();
    repeat (104) tick();
    snap = hv_reg_din;
    do_write(6'd1, 16'd77);
    do_write(6'd32, 16'h0001);
    do_read(6'd34, 16'h0003, "s2_status_pending");
    changed = 1'b0;
    n = 0;
    while (busy && n < 6000) begin
      if (hv_reg_din !== snap) changed = 1'b1;
      n++;
      tick();
    end
    check("s2_idle", 32'(busy), 0);
    check("s2_din_stable", 32'(changed), 0);
    check("s2_idle_upd", 32'(hv_update), 0);
    tick();
    check("s2_load_busy", 32'(busy), 1);
    check("s2_load_upd", 32'(hv_update), 0);
    check("s2_load_ch1_old", 32'(hv_reg_din[19:10]), 0);
    tick();
    check("s2_pulse_upd", 32'(hv_update), 1);
    check("s2_pulse_ch1", 32'(hv_reg_din[19:10]), 77);
    wait_idle("s2_end_idle");

    // Auto-commit: a channel write starts an update; writes in HOLD coalesce
    do_write(6'd32, 16'h0002);
    do_read(6'd32, 16'h0002, "s4_ctrl_rb");
    do_write(6'd3, 16'd200);
    check("s4_auto_load", 32'(busy), 1);
    tick();
    check("s4_auto_upd", 32'(hv_update), 1);
    check("s4_ch3", 32'(hv_reg_din[39:30]), 200);
    repeat (10) tick();
    do_write(6'd8, 16'd11);
    do_write(6'd9, 16'd22);
    do_write(6'd10, 16'd33);
    prev = hv_update;
    rises = 0;
    repeat (8400) begin
      tick();
      if (hv_update && !prev) rises++;
      prev = hv_update;
    end
    check("s4_one_extra_pulse", 32'(rises), 1);
    check("s4_idle", 32'(busy), 0);
    check("s4_ch8", 32'(hv_reg_din[89:80]), 11);
    check("s4_ch9", 32'(hv_reg_din[99:90]), 22);
    check("s4_ch10", 32'(hv_reg_din[109:100]), 33);

    // Reset mid-pulse aborts without waiting for a clock edge
    do_write(6'd0, 16'd5);
    tick();
    check("s5_pre_upd", 32'(hv_update), 1);
    #2;
    reset = 1'b0;
    #1;
    check("s5_async_upd", 32'(hv_update), 0);
    check("s5_async_busy", 32'(busy), 0);
    check("s5_async_din", 32'(|hv_reg_din), 0);
    repeat (2) @(posedge clkin);
    @(negedge clkin);
    reset = 1'b1;
    tick();
    do_read(6'd32, 16'h0000, "s5_ctrl_rb");
    do_read(6'd34, 16'h0000, "s5_status_rb");
    do_read(6'd0, 16'h0000, "s5_ch0_rb");
    run_commit_check("s5");

    tick();
    tick();
    check("sb_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hv_dac_reg_bank.md
Name: hv_dac_reg_bank

Overview:
- Upstream feeder for the HV DAC serializer (dac_ctrl_fsm).
- Holds 32 channel HV settings of 10 bits each, written over the DCS register bus into a shadow bank.
- On commit, copies the shadow bank into the active bank, which drives the serializer's 320-bit `hv_reg_din`, and issues the `hv_update` strobe.
- Enforces a minimum spacing between updates so the serializer is never retriggered mid-transfer, and saturates values above a programmable limit.

Parameters:
- NCH, 32, number of HV channels; `hv_reg_din` width is NCH*10.
- PULSE_LEN, 4, `hv_update` high time in clkin cycles (1..15).
- HOLDOFF, 4096, clkin cycles after an update start during which no new update is issued (16-bit counter).
- HV_MAX_RST, 10'h3FF, reset value of the clamp limit register.

Ports:
- clkin  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  single-cycle register write strobe.
- wr_addr  in  6  write address.
- wr_data  in  16  write data.
- rd_en  in  1  single-cycle register read strobe.
- rd_addr  in  6  read address.
- rd_data  out  16  read data.
- rd_valid  out  1  read data valid, one cycle.
- hv_reg_din  out  NCH*10  active bank; channel k occupies bits [10k+9:10k].
- hv_update  out  1  update strobe to the DAC serializer.
- busy  out  1  high while the update pulse or holdoff is running.

Behaviour:
- Reset (reset=0, asynchronous):
  - Shadow bank, active bank, `hv_reg_din`, `rd_data`, `rd_valid`, `hv_update` and `busy` all 0.
  - `auto_commit`=0, `pending`=0, `clamp_flag`=0, HV_MAX=HV_MAX_RST, FSM in IDLE, counters 0.
  - Reset asserted mid-pulse or mid-holdoff aborts immediately; `hv_update` drops asynchronously.
- Address map:
  - 0..NCH-1: shadow channel value, R/W, `wr_data[9:0]`.
  - 32: CTRL. Write bit0=1 requests a commit (self-clearing). bit1 = `auto_commit`, R/W. Readback is {14'b0, `auto_commit`, 1'b0}.
  - 33: HV_MAX, R/W, bits[9:0].
  - 34: STATUS, RO. Bit0 `busy`, bit1 `pending`, bit2 `clamp_flag`. Reading address 34 clears `clamp_flag` in the same cycle as the read strobe.
  - Writes to 34 and to unmapped addresses are ignored. Reads of unmapped addresses return 0.
- Channel writes:
  - If `wr_data[9:0]` > HV_MAX, store HV_MAX and set `clamp_flag` (sticky).
  - Upper `wr_data` bits are ignored.
  - Writing a new HV_MAX does not re-clamp values already stored.
- Reads:
  - `rd_en` at cycle N gives `rd_data`/`rd_valid` at N+1.
  - `rd_data` holds its value after `rd_valid` drops.
  - A read and a write to the same address in the same cycle returns the old value.
- Commit request sources:
  - CTRL bit0 write.
  - A channel write while `auto_commit`=1.
  - Multiple requests before service coalesce into one (`pending` is a single bit).
- FSM states:
  - IDLE: if `pending` or a new request is present, go to LOAD.
  - LOAD (1 cycle): active bank <= shadow bank, clear `pending`, go to PULSE.
    - A channel write in the same cycle as LOAD is not included in this copy. It sets `pending` if it is itself a request.
  - PULSE: `hv_update`=1 for exactly PULSE_LEN cycles, starting the cycle after LOAD. Then go to HOLD.
  - HOLD: counter runs until HOLDOFF cycles have elapsed since PULSE entry. Then go to IDLE.
- Latency and busy:
  - Commit write at cycle N (FSM idle): LOAD at N+1, `hv_update` high N+2..N+1+PULSE_LEN, `hv_reg_din` changes at N+2.
  - `busy`=1 in LOAD, PULSE and HOLD.
  - A request while busy sets `pending`. It is serviced on the first IDLE cycle, with no idle gap beyond one cycle.
- Active bank stability: `hv_reg_din` changes only in LOAD, never during PULSE or HOLD.

Test Plan:
- Reset release, write ch0=1, ch31=32, CTRL=1 -> `hv_reg_din[9:0]`=1 and `[319:310]`=32 two cycles after the CTRL write. `hv_update` high exactly 4 cycles. `busy` low 4096+1 cycles after PULSE entry.
- Second CTRL=1 commit issued 100 cycles into HOLD -> STATUS bit1=1. Next `hv_update` rises exactly 1 cycle after IDLE re-entry (LOAD, then PULSE). No `hv_reg_din` change before that LOAD.
- HV_MAX=500, write ch5=800 -> ch5 readback 500, STATUS=0x4. Second STATUS read returns 0x0.
- `auto_commit`=1, write ch3=200 -> update sequence starts without a CTRL write. Three more writes during HOLD -> exactly one additional `hv_update` pulse, with all three values present.
- Reset pulled low during PULSE -> `hv_update`, `busy` and `hv_reg_din` go to 0 without waiting for a clock edge. After release, CTRL readback is 0 and the next commit behaves as in the first scenario.
- Read addr 40 -> `rd_data`=0 with `rd_valid`. Same-cycle read and write of ch7 (old 10, new 20) -> `rd_data`=10, then a subsequent read returns 20.
